// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : core data-memory responder (word RAM + TOHOST/CYCLE MMIO)
// Optional macro DMEM_CYCLE_CNT_EN adds a free-running cycle counter at MMIO_BASE+4.
// Revision: 1.0
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wr_data_i,
  input  logic        dmem_write_i,
  input  logic        dmem_read_i,
  output logic [31:0] dmem_rd_data_o,
  output logic        host_valid_o,
  output logic [31:0] host_data_o,
  input  logic        host_ready_i,
  output logic        err_o,
  output logic        ovf_o
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES   = 32'(DEPTH) << 2;
  localparam logic [31:0] TOHOST_ADDR = MMIO_BASE;
  localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + 32'd4;

  logic [31:0]   mem [DEPTH];
  logic          w_aligned;
  logic          w_ram_hit;
  logic          w_tohost;
  logic          w_cycle;
  logic          w_bad;
  logic          w_host_wr;
  logic [AW-1:0] w_index;
  logic          r_host_valid;
  logic [31:0]   r_host_data;
  logic          r_err;
  logic          r_ovf;

  assign w_aligned = (dmem_addr_i[1:0] == 2'b00);
  assign w_ram_hit = (dmem_addr_i < RAM_BYTES);
  assign w_tohost  = (dmem_addr_i == TOHOST_ADDR);
  assign w_index   = dmem_addr_i[AW+1:2];
  assign w_bad     = (dmem_read_i | dmem_write_i) &
                     (~w_aligned | ~(w_ram_hit | w_tohost | w_cycle));
  assign w_host_wr = dmem_write_i & w_tohost & w_aligned;

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] r_cycle;

  assign w_cycle = (dmem_addr_i == CYCLE_ADDR);

  // A write preloads the value the next cycle should observe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cycle <= 32'd0;
    end else if (dmem_write_i && w_cycle && w_aligned) begin
      r_cycle <= dmem_wr_data_i + 32'd1;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end
`else
  assign w_cycle = 1'b0 & (dmem_addr_i == CYCLE_ADDR);
`endif

  // Combinational read returns the pre-write word when a store hits the same cycle.
  always_comb begin
    dmem_rd_data_o = 32'd0;
    if (dmem_read_i && w_aligned) begin
      if (w_ram_hit) begin
        dmem_rd_data_o = mem[w_index];
      end else if (w_tohost) begin
        dmem_rd_data_o = {31'd0, r_host_valid};
      end
`ifdef DMEM_CYCLE_CNT_EN
      else if (w_cycle) begin
        dmem_rd_data_o = r_cycle;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && dmem_write_i && w_aligned && w_ram_hit) begin
      mem[w_index] <= dmem_wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_host_valid <= 1'b0;
      r_host_data  <= 32'd0;
      r_err        <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_bad) begin
        r_err <= 1'b1;
      end
      // A handshake in the same cycle frees the slot, so the new word goes in without a bubble.
      if (w_host_wr) begin
        if (!r_host_valid || host_ready_i) begin
          r_host_data  <= dmem_wr_data_i;
          r_host_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_host_valid && host_ready_i) begin
        r_host_valid <= 1'b0;
      end
    end
  end

  assign host_valid_o = r_host_valid;
  assign host_data_o  = r_host_data;
  assign err_o        = r_err;
  assign ovf_o        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : scoreboard bench for dmem_responder (RAM, MMIO, errors)
// Revision: 1.0
// ============================================================================
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        write;
  logic        read;
  logic [31:0] rd_data;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;
  logic        err;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [int unsigned];
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_err;
  bit          m_ovf;
  logic [31:0] m_cycle;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .MMIO_BASE(BASE)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .dmem_addr_i    (addr),
    .dmem_wr_data_i (wr_data),
    .dmem_write_i   (write),
    .dmem_read_i    (read),
    .dmem_rd_data_o (rd_data),
    .host_valid_o   (host_valid),
    .host_data_o    (host_data),
    .host_ready_i   (host_ready),
    .err_o          (err),
    .ovf_o          (ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit cnt_en();
`ifdef DMEM_CYCLE_CNT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_bad(input logic [31:0] a);
    logic [1:0] lo;
    lo = a[1:0];
    if (lo != 2'b00) return 1'b1;
    if (a < 32'h0000_1000) return 1'b0;
    if (a == BASE) return 1'b0;
    if (cnt_en() && a == BASE + 32'd4) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_bad(a)) return 32'd0;
    if (a < 32'h0000_1000) return m_mem.exists(a >> 2) ? m_mem[a >> 2] : 32'd0;
    if (a == BASE) return {31'd0, m_valid};
    return m_cycle;
  endfunction

  // One clock of stimulus: expected load data queued on drive, popped when sampled.
  task automatic access(input bit rd, input bit wr, input bit rs, input bit rdy,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] got;
    @(negedge clk);
    rst        = rs;
    read       = rd;
    write      = wr;
    host_ready = rdy;
    addr       = a;
    wr_data    = wd;
    exp_q.push_back(rd ? model_read(a) : 32'd0);
    #1;
    got = rd_data;
    check_eq({tag, "/rd"}, got, exp_q.pop_front());
    if (rs) begin
      m_valid = 1'b0;
      m_data  = 32'd0;
      m_err   = 1'b0;
      m_ovf   = 1'b0;
      m_cycle = 32'd0;
    end else begin
      if ((rd || wr) && model_bad(a)) m_err = 1'b1;
      if (wr && !model_bad(a) && a < 32'h0000_1000) m_mem[a >> 2] = wd;
      if (cnt_en() && wr && a == BASE + 32'd4) m_cycle = wd + 32'd1;
      else m_cycle = m_cycle + 32'd1;
      if (wr && a == BASE) begin
        if (!m_valid || rdy) begin
          m_data  = wd;
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_eq({tag, "/valid"}, {31'd0, host_valid}, {31'd0, m_valid});
    check_eq({tag, "/hdata"}, host_data, m_data);
    check_eq({tag, "/err"}, {31'd0, err}, {31'd0, m_err});
    check_eq({tag, "/ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; read = 1'b0; write = 1'b0; host_ready = 1'b0;
    addr = 32'd0; wr_data = 32'd0;
    m_valid = 1'b0; m_data = 32'd0; m_err = 1'b0; m_ovf = 1'b0; m_cycle = 32'd0;

    access(0, 0, 1, 0, 32'h0, 32'h0, "reset");

    // Store then load, and same-cycle load/store ordering.
    access(0, 1, 0, 0, 32'h10, 32'hDEADBEEF, "st10");
    access(1, 0, 0, 0, 32'h10, 32'h0, "ld10");
    access(1, 1, 0, 0, 32'h10, 32'h1111_1111, "ldst10");
    access(1, 0, 0, 0, 32'h10, 32'h0, "ld10b");

    for (int i = 0; i < 64; i++) access(0, 1, 0, 0, 32'(i * 4), $urandom, "fill");
    access(0, 1, 0, 0, 32'hFFC, 32'hCAFE_F00D, "st_top");
    access(1, 0, 0, 0, 32'hFFC, 32'h0, "ld_top");
    access(1, 0, 0, 0, 32'h0, 32'h0, "ld_zero");
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 63) * 4);
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, a, $urandom, "rand");
    end

    // Misaligned and unmapped accesses.
    access(1, 0, 0, 0, 32'h12, 32'h0, "ld_mis");
    access(1, 0, 0, 0, 32'h10, 32'h0, "ld10_after_mis");
    access(0, 1, 0, 0, 32'h12, 32'h1234_5678, "st_mis");
    access(1, 0, 0, 0, 32'h10, 32'h0, "ld10_after_stmis");
    access(0, 0, 1, 0, 32'h0, 32'h0, "rst1");
    access(0, 1, 0, 0, 32'h8000, 32'h5555_AAAA, "st_unmap");
    access(1, 0, 0, 0, 32'h8000, 32'h0, "ld_unmap");
    access(1, 0, 0, 0, 32'h1000, 32'h0, "ld_ram_end");
    access(0, 0, 1, 0, 32'h0, 32'h0, "rst2");
    access(1, 0, 0, 0, BASE + 32'd4, 32'h0, "ld_cyc");
    access(0, 0, 1, 0, 32'h0, 32'h0, "rst3");

    // Mailbox: overflow when full and not ready.
    access(0, 1, 0, 0, BASE, 32'h5, "mb_st5");
    access(0, 1, 0, 0, BASE, 32'h6, "mb_st6_drop");
    access(1, 0, 0, 0, BASE, 32'h0, "mb_ld");
    access(0, 0, 1, 0, 32'h0, 32'h0, "rst4");

    // Mailbox: handshake coinciding with a new store.
    access(0, 1, 0, 0, BASE, 32'h5, "mb2_st5");
    access(0, 1, 0, 1, BASE, 32'h7, "mb2_st7_rdy");
    access(1, 0, 0, 0, BASE, 32'h0, "mb2_ld1");
    access(0, 0, 0, 1, 32'h0, 32'h0, "mb2_drain");
    access(1, 0, 0, 0, BASE, 32'h0, "mb2_ld0");

    // Reset with a pending word, sticky flags set and a store in flight.
    access(0, 1, 0, 0, 32'h20, 32'hAAAA_5555, "r5_st20");
    access(0, 1, 0, 0, BASE, 32'h9, "r5_mb9");
    access(1, 0, 0, 0, 32'h12, 32'h0, "r5_err");
    access(0, 1, 0, 0, BASE, 32'hA, "r5_ovf");
    access(0, 1, 1, 0, 32'h20, 32'h0BAD_0BAD, "r5_rst_st");
    access(1, 0, 0, 0, 32'h20, 32'h0, "r5_ld20");

    // Cycle counter wrap (unmapped when the counter is not built in).
    access(0, 1, 0, 0, BASE + 32'd4, 32'hFFFF_FFFE, "cyc_wr");
    access(1, 0, 0, 0, BASE + 32'd4, 32'h0, "cyc_rd0");
    access(1, 0, 0, 0, BASE + 32'd4, 32'h0, "cyc_rd1");
    access(1, 0, 0, 0, BASE + 32'd4, 32'h0, "cyc_rd2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
